raster_sequencer: RTL and testbench

Front-end scheduler for the rasteriser pixel path. It buffers incoming triangles in a 4-entry queue and computes each triangle's screen-clamped bounding box. It then walks that box row-major, handing one pixel address at a time to the rasteriser/texture stage over a valid/ready handshake. It also signals per-triangle completion and emits a frame-ready pulse once a requested frame boundary has fully drained.

---
 rtl/raster_sequencer_if.sv | 37 +++
 rtl/raster_sequencer.sv | 179 +++++++++++++++++
 tb/tb_raster_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_sequencer_if.sv
// rtl/raster_sequencer_if.sv - triangle input and pixel output handshake bundle
//
// Groups the two streams of the raster sequencer:
//   tri_valid/tri_ready + x1..y3  : triangle push channel (upstream -> sequencer)
//   pixel_valid/pixel_ready + pixel_number/pixel_x/pixel_y : pixel channel (sequencer -> rasteriser)
// master : the environment side (drives triangles, accepts pixels)
// slave  : the sequencer side (accepts triangles, drives pixels)
interface raster_sequencer_if;
  logic        tri_valid;
  logic        tri_ready;
  logic [15:0] x1;
  logic [15:0] y1;
  logic [15:0] x2;
  logic [15:0] y2;
  logic [15:0] x3;
  logic [15:0] y3;

  logic        pixel_valid;
  logic        pixel_ready;
  logic [18:0] pixel_number;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;

  modport master (
    output tri_valid, x1, y1, x2, y2, x3, y3,
    input  tri_ready,
    input  pixel_valid, pixel_number, pixel_x, pixel_y,
    output pixel_ready
  );

  modport slave (
    input  tri_valid, x1, y1, x2, y2, x3, y3,
    output tri_ready,
    output pixel_valid, pixel_number, pixel_x, pixel_y,
    input  pixel_ready
  );
endinterface

// File: rtl/raster_sequencer.sv
// rtl/raster_sequencer.sv - triangle queue, bounding-box walker and frame drain tracker
//
// Ports:
//   clk           : system clock, rising edge
//   reset         : asynchronous active-high reset
//   bus           : raster_sequencer_if.slave (triangle push channel, pixel output channel)
//   frame_end     : single-cycle request to close the frame after queued work drains
//   triangle_done : one-cycle pulse after the last pixel (or skip) of a triangle
//   frame_ready_o : one-cycle pulse once a requested frame has fully drained
//   busy          : walker active or queue non-empty
module raster_sequencer #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int QDEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset,
  raster_sequencer_if.slave   bus,
  input  logic                frame_end,
  output logic                triangle_done,
  output logic                frame_ready_o,
  output logic                busy
);

  localparam int XW = 10;
  localparam int YW = 9;
  localparam int NW = 19;
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  typedef struct packed {
    logic [15:0] x1, y1, x2, y2, x3, y3;
  } tri_entry_t;

  state_t     state, state_next;
  tri_entry_t queue_mem [QDEPTH];
  tri_entry_t head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          frame_pend;

  logic [XW-1:0] min_x_r, max_x_r, pixel_x_r;
  logic [YW-1:0] max_y_r, pixel_y_r;
  logic [NW-1:0] row_base, pixel_number_r;

  logic push, pop, pix_fire, at_row_end, at_last, skip;
  logic tri_done_c, frame_fire, pix_valid_c;
  logic [15:0]   bb_min_x, bb_max_x, bb_min_y, bb_max_y;
  logic [XW-1:0] bb_max_x_c;
  logic [YW-1:0] bb_max_y_c, bb_min_y_n;
  logic [NW-1:0] row_base_init;

  function automatic logic [15:0] min3(input logic [15:0] a, b, c);
    logic [15:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [15:0] max3(input logic [15:0] a, b, c);
    logic [15:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  assign head     = queue_mem[rd_ptr];
  assign bb_min_x = min3(head.x1, head.x2, head.x3);
  assign bb_max_x = max3(head.x1, head.x2, head.x3);
  assign bb_min_y = min3(head.y1, head.y2, head.y3);
  assign bb_max_y = max3(head.y1, head.y2, head.y3);

  // A box starting off-screen has no visible pixel; anything else is clamped
  // on its far edge only, so the narrowed fields below are always in range.
  assign skip       = (bb_min_x > 16'(SCREEN_W - 1)) || (bb_min_y > 16'(SCREEN_H - 1));
  assign bb_max_x_c = (bb_max_x > 16'(SCREEN_W - 1)) ? XW'(SCREEN_W - 1) : bb_max_x[XW-1:0];
  assign bb_max_y_c = (bb_max_y > 16'(SCREEN_H - 1)) ? YW'(SCREEN_H - 1) : bb_max_y[YW-1:0];
  assign bb_min_y_n = bb_min_y[YW-1:0];

  // y*640 as y*512 + y*128; avoids a multiplier for the one-off row base.
  assign row_base_init = NW'({bb_min_y_n, 9'b0}) + NW'({bb_min_y_n, 7'b0});

  assign bus.tri_ready = (count != CW'(QDEPTH));
  assign push          = bus.tri_valid && bus.tri_ready;
  assign pop           = (state == LOAD);
  assign pix_fire      = (state == SCAN) && bus.pixel_ready;
  assign at_row_end    = (pixel_x_r == max_x_r);
  assign at_last       = at_row_end && (pixel_y_r == max_y_r);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    tri_done_c  = 1'b0;
    frame_fire  = 1'b0;
    pix_valid_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          state_next = LOAD;
        end else begin
          if (frame_pend) frame_fire = 1'b1;
          // Pushing into an empty idle queue goes straight to LOAD next cycle.
          if (push) state_next = LOAD;
        end
      end
      LOAD: state_next = skip ? DONE : SCAN;
      SCAN: begin
        pix_valid_c = 1'b1;
        if (bus.pixel_ready && at_last) state_next = DONE;
      end
      DONE: begin
        tri_done_c = 1'b1;
        state_next = (count != '0) ? LOAD : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) queue_mem[wr_ptr] <= tri_entry_t'({bus.x1, bus.y1, bus.x2, bus.y2, bus.x3, bus.y3});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      frame_pend     <= 1'b0;
      min_x_r        <= '0;
      max_x_r        <= '0;
      max_y_r        <= '0;
      pixel_x_r      <= '0;
      pixel_y_r      <= '0;
      row_base       <= '0;
      pixel_number_r <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      // A repeat request while one is pending merges into it.
      if (frame_fire)     frame_pend <= 1'b0;
      else if (frame_end) frame_pend <= 1'b1;

      if (pop && !skip) begin
        min_x_r        <= bb_min_x[XW-1:0];
        max_x_r        <= bb_max_x_c;
        max_y_r        <= bb_max_y_c;
        pixel_x_r      <= bb_min_x[XW-1:0];
        pixel_y_r      <= bb_min_y_n;
        row_base       <= row_base_init;
        pixel_number_r <= row_base_init + NW'(bb_min_x[XW-1:0]);
      end else if (pix_fire && !at_last) begin
        if (at_row_end) begin
          pixel_x_r      <= min_x_r;
          pixel_y_r      <= pixel_y_r + 1'b1;
          row_base       <= row_base + NW'(SCREEN_W);
          pixel_number_r <= row_base + NW'(SCREEN_W) + NW'(min_x_r);
        end else begin
          pixel_x_r      <= pixel_x_r + 1'b1;
          pixel_number_r <= pixel_number_r + 1'b1;
        end
      end
    end
  end

  assign bus.pixel_valid  = pix_valid_c;
  assign bus.pixel_x      = pixel_x_r;
  assign bus.pixel_y      = pixel_y_r;
  assign bus.pixel_number = pixel_number_r;
  assign triangle_done    = tri_done_c;
  assign frame_ready_o    = frame_fire;
  assign busy             = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_raster_sequencer.sv
// tb/tb_raster_sequencer.sv - self-checking bench for raster_sequencer
module tb_raster_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic frame_end;
  logic triangle_done, frame_ready_o, busy;

  raster_sequencer_if bus ();

  raster_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .frame_end     (frame_end),
    .triangle_done (triangle_done),
    .frame_ready_o (frame_ready_o),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x1, y1, x2, y2, x3, y3;
  } tri_t;

  typedef struct {
    tri_t t;
    int   exp_pix;
    int   exp_first;
    int   exp_last;
  } vec_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [18:0] n;
  } pix_t;

  pix_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   pix_seen = 0, done_seen = 0, frame_seen = 0;
  int   last_done_cyc = -1, frame_cyc = -1, first_valid_cyc = -1, push_cyc = -1;
  int   first_num = -1, last_num = -1;
  logic hold_v = 1'b0;
  pix_t hold_p;
  vec_t vt[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic tri_t mk_tri(input int a, b, c, d, e, f);
    tri_t t;
    t.x1 = 16'(a); t.y1 = 16'(b); t.x2 = 16'(c);
    t.y2 = 16'(d); t.x3 = 16'(e); t.y3 = 16'(f);
    return t;
  endfunction

  function automatic vec_t mk_vec(input tri_t t, input int np, input int f, input int l);
    vec_t v;
    v.t = t; v.exp_pix = np; v.exp_first = f; v.exp_last = l;
    return v;
  endfunction

  // Reference walk: pixel number by multiplication, independent of the shift-add path.
  task automatic sb_add(input tri_t t);
    int mnx, mxx, mny, mxy;
    pix_t p;
    mnx = t.x1; if (t.x2 < mnx) mnx = t.x2; if (t.x3 < mnx) mnx = t.x3;
    mxx = t.x1; if (t.x2 > mxx) mxx = t.x2; if (t.x3 > mxx) mxx = t.x3;
    mny = t.y1; if (t.y2 < mny) mny = t.y2; if (t.y3 < mny) mny = t.y3;
    mxy = t.y1; if (t.y2 > mxy) mxy = t.y2; if (t.y3 > mxy) mxy = t.y3;
    if (mnx > 639 || mny > 479) return;
    if (mxx > 639) mxx = 639;
    if (mxy > 479) mxy = 479;
    for (int y = mny; y <= mxy; y++)
      for (int x = mnx; x <= mxx; x++) begin
        p.x = 10'(x); p.y = 9'(y); p.n = 19'(y * 640 + x);
        sb.push_back(p);
      end
  endtask

  task automatic push_tri(input tri_t t, input int max_wait, output bit ok);
    bus.x1 = t.x1; bus.y1 = t.y1; bus.x2 = t.x2;
    bus.y2 = t.y2; bus.x3 = t.x3; bus.y3 = t.y3;
    bus.tri_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < max_wait && !ok; k++) begin
      @(negedge clk);
      if (bus.tri_ready) begin
        ok = 1'b1;
        push_cyc = cyc;
        sb_add(t);
      end
      @(posedge clk); #1;
    end
    bus.tri_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int maxc);
    for (int k = 0; k < maxc && done_seen < target; k++) begin
      @(posedge clk); #1;
    end
    check("triangle_done_count", done_seen, target);
  endtask

  task automatic wait_valid(input int maxc);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < maxc && !seen; k++) begin
      @(negedge clk);
      seen = bus.pixel_valid;
    end
    check("pixel_valid_reached", seen, 1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard pops on handshake, stall stability, pulse bookkeeping.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("stall_valid_held", bus.pixel_valid, 1);
          check("stall_outputs_held", {bus.pixel_x, bus.pixel_y, bus.pixel_number}, hold_p);
          hold_v = 1'b0;
        end
        if (bus.pixel_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.pixel_valid && bus.pixel_ready) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_pixel: got n=%0d, expected no pixel", bus.pixel_number);
          end else begin
            check("pixel", {bus.pixel_x, bus.pixel_y, bus.pixel_number}, sb.pop_front());
          end
          pix_seen++;
          if (pix_seen == 1) first_num = bus.pixel_number;
          last_num = bus.pixel_number;
        end else if (bus.pixel_valid) begin
          hold_v = 1'b1;
          hold_p = {bus.pixel_x, bus.pixel_y, bus.pixel_number};
        end
        if (triangle_done) begin done_seen++; last_done_cyc = cyc; end
        if (frame_ready_o) begin frame_seen++; frame_cyc = cyc; end
      end
    end
  end

  initial begin
    bit ok;
    int d0, f0, acc;

    vt[0] = mk_vec(mk_tri(10, 20, 12, 20, 10, 21), 6, 12810, 13452);
    vt[1] = mk_vec(mk_tri(630, 475, 700, 475, 630, 600), 50, 304630, 307199);
    vt[2] = mk_vec(mk_tri(700, 10, 800, 10, 700, 20), 0, 0, 0);
    vt[3] = mk_vec(mk_tri(5, 5, 5, 5, 5, 5), 1, 3205, 3205);
    vt[4] = mk_vec(mk_tri(3, 0, 0, 1, 0, 0), 8, 0, 643);
    vt[5] = mk_vec(mk_tri(100, 480, 101, 480, 100, 490), 0, 0, 0);
    vt[6] = mk_vec(mk_tri(639, 479, 639, 479, 639, 479), 1, 307199, 307199);
    vt[7] = mk_vec(mk_tri(639, 100, 0, 101, 320, 100), 1280, 64000, 65279);

    reset = 1'b1;
    frame_end = 1'b0;
    bus.tri_valid = 1'b0;
    bus.pixel_ready = 1'b0;
    bus.x1 = '0; bus.y1 = '0; bus.x2 = '0; bus.y2 = '0; bus.x3 = '0; bus.y3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel_valid", bus.pixel_valid, 0);
    check("rst_pixel_number", bus.pixel_number, 0);
    check("rst_pixel_x", bus.pixel_x, 0);
    check("rst_pixel_y", bus.pixel_y, 0);
    check("rst_triangle_done", triangle_done, 0);
    check("rst_frame_ready", frame_ready_o, 0);
    check("rst_busy", busy, 0);
    check("rst_tri_ready", bus.tri_ready, 1);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Table: one triangle at a time, downstream always ready.
    bus.pixel_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pix_seen = 0; first_num = -1; last_num = -1; first_valid_cyc = -1;
      d0 = done_seen;
      push_tri(vt[i].t, 10, ok);
      check("push_accepted", ok, 1);
      wait_done(d0 + 1, 2000);
      check("pixel_count", pix_seen, vt[i].exp_pix);
      if (vt[i].exp_pix > 0) begin
        check("first_number", first_num, vt[i].exp_first);
        check("last_number", last_num, vt[i].exp_last);
      end else begin
        check("skip_done_latency", last_done_cyc, push_cyc + 2);
      end
      if (i == 0) check("first_pixel_latency", first_valid_cyc, push_cyc + 2);
      check("scoreboard_empty", sb.size(), 0);
      repeat (2) @(posedge clk);
      #1;
      check("idle_busy", busy, 0);
    end

    // Backpressure: ready toggles every cycle.
    bus.pixel_ready = 1'b0;
    pix_seen = 0;
    d0 = done_seen;
    push_tri(vt[0].t, 10, ok);
    for (int k = 0; k < 100 && done_seen < d0 + 1; k++) begin
      @(posedge clk); #1;
      bus.pixel_ready = ~bus.pixel_ready;
    end
    check("bp_done", done_seen, d0 + 1);
    check("bp_pixel_count", pix_seen, 6);
    check("bp_scoreboard_empty", sb.size(), 0);
    bus.pixel_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Queue full: one triangle stalled in SCAN, then five more offered.
    d0 = done_seen;
    push_tri(vt[0].t, 10, ok);
    wait_valid(10);
    @(posedge clk); #1;
    acc = 0;
    for (int j = 0; j < 5; j++) begin
      push_tri(mk_tri(30 + 2 * j, 40, 30 + 2 * j, 40, 30 + 2 * j, 40), 8, ok);
      if (ok) acc++;
      else break;
    end
    check("qfull_accepts", acc, 4);
    check("qfull_tri_ready", bus.tri_ready, 0);
    check("qfull_busy", busy, 1);
    bus.pixel_ready = 1'b1;
    push_tri(mk_tri(38, 40, 38, 40, 38, 40), 200, ok);
    check("qfull_fifth_accepted", ok, 1);
    wait_done(d0 + 6, 500);
    check("qfull_scoreboard_empty", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;

    // Frame drain with two triangles outstanding; second request merges.
    bus.pixel_ready = 1'b0;
    d0 = done_seen;
    f0 = frame_seen;
    push_tri(vt[0].t, 10, ok);
    push_tri(vt[3].t, 10, ok);
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("frame_not_early", frame_seen, f0);
    bus.pixel_ready = 1'b1;
    wait_done(d0 + 2, 200);
    repeat (6) @(posedge clk);
    #1;
    check("frame_pulse_count", frame_seen, f0 + 1);
    check("frame_after_last_done", frame_cyc, last_done_cyc + 1);
    check("frame_scoreboard_empty", sb.size(), 0);

    // Reset while the third pixel is presented.
    bus.pixel_ready = 1'b0;
    push_tri(vt[0].t, 10, ok);
    wait_valid(10);
    @(posedge clk); #1;
    bus.pixel_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    bus.pixel_ready = 1'b0;
    check("mid_scan_third_x", bus.pixel_x, 12);
    #2;
    reset = 1'b1;
    #1;
    check("arst_pixel_valid", bus.pixel_valid, 0);
    check("arst_pixel_number", bus.pixel_number, 0);
    check("arst_pixel_x", bus.pixel_x, 0);
    check("arst_pixel_y", bus.pixel_y, 0);
    check("arst_busy", busy, 0);
    check("arst_tri_ready", bus.tri_ready, 1);
    check("arst_triangle_done", triangle_done, 0);
    sb.delete();
    d0 = done_seen;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_no_done", done_seen, d0);
    check("post_rst_busy", busy, 0);
    bus.pixel_ready = 1'b1;
    pix_seen = 0; first_num = -1;
    push_tri(vt[0].t, 10, ok);
    wait_done(d0 + 1, 100);
    check("post_rst_pixel_count", pix_seen, 6);
    check("post_rst_first_number", first_num, 12810);
    check("post_rst_scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
